// File: rtl/msdap_out_serializer.sv
// -----------------------------------------------------------------------------
// msdap_out_serializer
//
// Transmit side of the MSDAP serial protocol. Accepts the 40-bit parallel
// left/right filter results from the msdap core (strobed by load/outready) and
// shifts them out MSB-first, one serial line per channel, in lockstep. A frame
// pulse marks bit 0 of every word. A one-deep holding buffer lets the core
// deliver the next result while the current one is still being shifted, so
// back-to-back words stream with no idle gap. A word that arrives while the
// buffer is still full is dropped and reported through a sticky overflow flag.
//
// Optional feature (compile-time macro SER_PARITY_EN):
//   When defined, an even-parity bit (XOR of the WIDTH data bits) follows the
//   data bits of each channel, making a frame WIDTH+1 bits long. frame_out is
//   low during the parity bit; busy covers it.
//
// Parameters:
//   WIDTH    - bits per channel word
//   BIT_DIV  - sclk cycles each serial bit is held (>= 1)
//   CNT_BITS - bit counter width, 2^CNT_BITS > WIDTH+1
//
// Ports:
//   sclk        in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   load        in   one-cycle strobe, dataL/dataR valid
//   dataL/dataR in   parallel channel words
//   serial_outL out  left serial data, MSB first
//   serial_outR out  right serial data, MSB first
//   frame_out   out  high for the whole of bit 0 of each word
//   busy        out  high while a word is being shifted
//   ready       out  high when the holding buffer is empty
//   overflow    out  sticky, set when a word is dropped
//
// All outputs are registered; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module msdap_out_serializer #(
    parameter int WIDTH    = 40,
    parameter int BIT_DIV  = 4,
    parameter int CNT_BITS = 6
) (
    input  logic             sclk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] dataL,
    input  logic [WIDTH-1:0] dataR,
    output logic             serial_outL,
    output logic             serial_outR,
    output logic             frame_out,
    output logic             busy,
    output logic             ready,
    output logic             overflow
);

`ifdef SER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    // A divider of 1 still needs a one-bit counter that simply stays at 0.
    localparam int DIV_BITS = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

`ifdef SER_PARITY_EN
    // Even parity over one channel word: XOR of all data bits.
    function automatic logic f_even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    // State and datapath registers
    state_t                r_state;
    logic                  r_hold_valid;
    logic [WIDTH-1:0]      r_hold_l;
    logic [WIDTH-1:0]      r_hold_r;
    logic [FRAME_LEN-1:0]  r_shift_l;
    logic [FRAME_LEN-1:0]  r_shift_r;
    logic [CNT_BITS-1:0]   r_bit_cnt;
    logic [DIV_BITS-1:0]   r_div_cnt;
    logic                  r_serial_l;
    logic                  r_serial_r;
    logic                  r_frame;
    logic                  r_busy;
    logic                  r_ready;
    logic                  r_overflow;

    // Next-state values
    state_t                w_state_n;
    logic                  w_hold_valid_n;
    logic [WIDTH-1:0]      w_hold_l_n;
    logic [WIDTH-1:0]      w_hold_r_n;
    logic [FRAME_LEN-1:0]  w_shift_l_n;
    logic [FRAME_LEN-1:0]  w_shift_r_n;
    logic [CNT_BITS-1:0]   w_bit_cnt_n;
    logic [DIV_BITS-1:0]   w_div_cnt_n;
    logic                  w_serial_l_n;
    logic                  w_serial_r_n;
    logic                  w_frame_n;
    logic                  w_busy_n;
    logic                  w_ready_n;
    logic                  w_overflow_n;

    logic                  w_bit_end;    // last sclk cycle of the current bit
    logic                  w_frame_end;  // current bit is the last of the frame
    logic                  w_xfer;       // holding buffer moves to shifter this edge

    assign w_bit_end   = (r_div_cnt == DIV_BITS'(BIT_DIV - 1));
    assign w_frame_end = (r_bit_cnt == CNT_BITS'(FRAME_LEN - 1));

    // Next-state, holding-buffer and registered-output computation
    always_comb begin
        w_state_n      = r_state;
        w_hold_valid_n = r_hold_valid;
        w_hold_l_n     = r_hold_l;
        w_hold_r_n     = r_hold_r;
        w_shift_l_n    = r_shift_l;
        w_shift_r_n    = r_shift_r;
        w_bit_cnt_n    = r_bit_cnt;
        w_div_cnt_n    = r_div_cnt;
        w_overflow_n   = r_overflow;
        w_xfer         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_hold_valid) begin
                    w_xfer = 1'b1;
                end else begin
                    w_xfer = 1'b0;
                end
            end
            S_SHIFT: begin
                if (w_bit_end) begin
                    if (w_frame_end) begin
                        // Chain straight into the buffered word so the stream
                        // has no idle cycle between frames.
                        if (r_hold_valid) begin
                            w_xfer = 1'b1;
                        end else begin
                            w_state_n = S_IDLE;
                        end
                    end else begin
                        w_shift_l_n = {r_shift_l[FRAME_LEN-2:0], 1'b0};
                        w_shift_r_n = {r_shift_r[FRAME_LEN-2:0], 1'b0};
                        w_bit_cnt_n = r_bit_cnt + CNT_BITS'(1);
                        w_div_cnt_n = DIV_BITS'(0);
                    end
                end else begin
                    w_div_cnt_n = r_div_cnt + DIV_BITS'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        if (w_xfer) begin
`ifdef SER_PARITY_EN
            w_shift_l_n = {r_hold_l, f_even_parity(r_hold_l)};
            w_shift_r_n = {r_hold_r, f_even_parity(r_hold_r)};
`else
            w_shift_l_n = r_hold_l;
            w_shift_r_n = r_hold_r;
`endif
            w_bit_cnt_n = CNT_BITS'(0);
            w_div_cnt_n = DIV_BITS'(0);
            w_state_n   = S_SHIFT;
        end else begin
            w_bit_cnt_n = w_bit_cnt_n;
        end

        // A buffer being emptied on this edge can accept a new word on the
        // same edge; only a buffer that stays full drops the word.
        if (load && (!r_hold_valid || w_xfer)) begin
            w_hold_l_n     = dataL;
            w_hold_r_n     = dataR;
            w_hold_valid_n = 1'b1;
        end else if (load) begin
            w_overflow_n   = 1'b1;
        end else if (w_xfer) begin
            w_hold_valid_n = 1'b0;
        end else begin
            w_hold_valid_n = r_hold_valid;
        end

        w_busy_n     = (w_state_n == S_SHIFT);
        w_serial_l_n = w_busy_n & w_shift_l_n[FRAME_LEN-1];
        w_serial_r_n = w_busy_n & w_shift_r_n[FRAME_LEN-1];
        w_frame_n    = w_busy_n & (w_bit_cnt_n == CNT_BITS'(0));
        w_ready_n    = ~w_hold_valid_n;
    end

    // State, datapath and output registers with asynchronous reset
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_hold_valid <= 1'b0;
            r_hold_l     <= {WIDTH{1'b0}};
            r_hold_r     <= {WIDTH{1'b0}};
            r_shift_l    <= {FRAME_LEN{1'b0}};
            r_shift_r    <= {FRAME_LEN{1'b0}};
            r_bit_cnt    <= CNT_BITS'(0);
            r_div_cnt    <= DIV_BITS'(0);
            r_serial_l   <= 1'b0;
            r_serial_r   <= 1'b0;
            r_frame      <= 1'b0;
            r_busy       <= 1'b0;
            r_ready      <= 1'b1;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_hold_valid <= w_hold_valid_n;
            r_hold_l     <= w_hold_l_n;
            r_hold_r     <= w_hold_r_n;
            r_shift_l    <= w_shift_l_n;
            r_shift_r    <= w_shift_r_n;
            r_bit_cnt    <= w_bit_cnt_n;
            r_div_cnt    <= w_div_cnt_n;
            r_serial_l   <= w_serial_l_n;
            r_serial_r   <= w_serial_r_n;
            r_frame      <= w_frame_n;
            r_busy       <= w_busy_n;
            r_ready      <= w_ready_n;
            r_overflow   <= w_overflow_n;
        end
    end

    assign serial_outL = r_serial_l;
    assign serial_outR = r_serial_r;
    assign frame_out   = r_frame;
    assign busy        = r_busy;
    assign ready       = r_ready;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_msdap_out_serializer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for msdap_out_serializer.
// A word-level reference model (queue for the holding buffer, start time and
// arithmetic bit index for the word in flight) predicts every output on every
// cycle. On top of that, a table of single words and hand-written sequences
// cover framing, back-to-back streaming, overflow, load-on-transfer and reset.
// -----------------------------------------------------------------------------
module tb_msdap_out_serializer;

    localparam int WIDTH    = 40;
    localparam int BIT_DIV  = 4;
    localparam int CNT_BITS = 6;
`ifdef SER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
    localparam int PAR       = 1;
`else
    localparam int FRAME_LEN = WIDTH;
    localparam int PAR       = 0;
`endif
    localparam int FC = FRAME_LEN * BIT_DIV;

    logic             sclk = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] dataL;
    logic [WIDTH-1:0] dataR;
    logic             serial_outL;
    logic             serial_outR;
    logic             frame_out;
    logic             busy;
    logic             ready;
    logic             overflow;

    msdap_out_serializer #(
        .WIDTH   (WIDTH),
        .BIT_DIV (BIT_DIV),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .sclk       (sclk),
        .reset      (reset),
        .load       (load),
        .dataL      (dataL),
        .dataR      (dataR),
        .serial_outL(serial_outL),
        .serial_outR(serial_outR),
        .frame_out  (frame_out),
        .busy       (busy),
        .ready      (ready),
        .overflow   (overflow)
    );

    always #5 sclk = ~sclk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [FRAME_LEN-1:0] mk(input logic [WIDTH-1:0] d);
`ifdef SER_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    logic [FRAME_LEN-1:0] m_hl[$];
    logic [FRAME_LEN-1:0] m_hr[$];
    logic [FRAME_LEN-1:0] m_cur_l, m_cur_r;
    bit                   m_active;
    bit                   m_ovf;
    int                   m_edge;
    int                   m_start;

    always @(posedge sclk or posedge reset) begin
        if (reset) begin
            m_hl.delete();
            m_hr.delete();
            m_active = 1'b0;
            m_ovf    = 1'b0;
            m_edge   = 0;
            m_start  = 0;
        end else begin
            m_edge++;
            if (m_active && (m_edge - m_start == FC)) m_active = 1'b0;
            if (!m_active && m_hl.size() > 0) begin
                m_cur_l  = m_hl.pop_front();
                m_cur_r  = m_hr.pop_front();
                m_active = 1'b1;
                m_start  = m_edge;
            end
            if (load) begin
                if (m_hl.size() == 0) begin
                    m_hl.push_back(mk(dataL));
                    m_hr.push_back(mk(dataR));
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle
    always @(negedge sclk) begin : model_check
        int k;
        logic e_sl, e_sr;
        if (chk_en && !reset) begin
            k    = m_active ? (m_edge - m_start) / BIT_DIV : 0;
            e_sl = m_active ? m_cur_l[FRAME_LEN-1-k] : 1'b0;
            e_sr = m_active ? m_cur_r[FRAME_LEN-1-k] : 1'b0;
            chk("model_serial_outL", 64'(serial_outL), 64'(e_sl));
            chk("model_serial_outR", 64'(serial_outR), 64'(e_sr));
            chk("model_frame_out",   64'(frame_out),   64'(m_active && k == 0));
            chk("model_busy",        64'(busy),        64'(m_active));
            chk("model_ready",       64'(ready),       64'(m_hl.size() == 0));
            chk("model_overflow",    64'(overflow),    64'(m_ovf));
        end
    end

    // Frame rising-edge recorder
    int cyc = 0;
    bit prev_fr = 1'b0;
    int rise_q[$];
    always @(negedge sclk) begin
        if (frame_out && !prev_fr) rise_q.push_back(cyc);
        prev_fr = frame_out;
        cyc++;
    end

    // ---------------- helpers ----------------
    task automatic pulse_load(input logic [WIDTH-1:0] dl, input logic [WIDTH-1:0] dr);
        load  = 1'b1;
        dataL = dl;
        dataR = dr;
        @(negedge sclk);
        load  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic wait_idle(input string nm);
        int i;
        for (i = 0; i < 4 * FC; i++) begin
            if (!busy && ready) break;
            @(negedge sclk);
        end
        chk({nm, "_idle_timeout"}, 64'(i < 4 * FC), 64'(1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        @(negedge sclk);
    endtask

    typedef struct {
        logic [WIDTH-1:0] dl;
        logic [WIDTH-1:0] dr;
        int               pop_l;
        int               pop_r;
        logic             par_l;
        logic             par_r;
    } vec_t;

    vec_t tbl[4];

    task automatic run_word(input vec_t v, input string nm);
        int busy_n = 0, frame_n = 0, ones_l = 0, ones_r = 0, first = -1;
        logic [FRAME_LEN-1:0] rx_l = '0, rx_r = '0, exp_l, exp_r;
        load  = 1'b1;
        dataL = v.dl;
        dataR = v.dr;
        for (int s = 1; s <= FC + 20; s++) begin
            @(negedge sclk);
            if (s == 1) load = 1'b0;
            if (frame_out && first < 0) first = s;
            if (frame_out) frame_n++;
            if (serial_outL) ones_l++;
            if (serial_outR) ones_r++;
            if (busy) begin
                if (busy_n % BIT_DIV == 0) begin
                    rx_l = {rx_l[FRAME_LEN-2:0], serial_outL};
                    rx_r = {rx_r[FRAME_LEN-2:0], serial_outR};
                end
                busy_n++;
            end
        end
`ifdef SER_PARITY_EN
        exp_l = {v.dl, v.par_l};
        exp_r = {v.dr, v.par_r};
`else
        exp_l = v.dl;
        exp_r = v.dr;
`endif
        chk({nm, "_busy_cycles"},  64'(busy_n),  64'(FC));
        chk({nm, "_frame_cycles"}, 64'(frame_n), 64'(BIT_DIV));
        chk({nm, "_first_frame"},  64'(first),   64'(2));
        chk({nm, "_ones_L"}, 64'(ones_l), 64'((v.pop_l + (PAR != 0 ? int'(v.par_l) : 0)) * BIT_DIV));
        chk({nm, "_ones_R"}, 64'(ones_r), 64'((v.pop_r + (PAR != 0 ? int'(v.par_r) : 0)) * BIT_DIV));
        chk({nm, "_rx_L"}, 64'(rx_l), 64'(exp_l));
        chk({nm, "_rx_R"}, 64'(rx_r), 64'(exp_r));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] rnd;
        tbl[0] = '{40'h80_0000_0001, 40'h00_0000_0000,  2,  0, 1'b0, 1'b0};
        tbl[1] = '{40'h00_0000_0007, 40'h00_0000_0003,  3,  2, 1'b1, 1'b0};
        tbl[2] = '{40'hFF_FFFF_FFFF, 40'h55_5555_5555, 40, 20, 1'b0, 1'b0};
        tbl[3] = '{40'h12_3456_789A, 40'h00_0000_0001, 17,  1, 1'b1, 1'b1};

        reset = 1'b1;
        load  = 1'b0;
        dataL = '0;
        dataR = '0;
        wait_cycles(3);
        chk("rst_serial_outL", 64'(serial_outL), 64'(0));
        chk("rst_serial_outR", 64'(serial_outR), 64'(0));
        chk("rst_frame_out",   64'(frame_out),   64'(0));
        chk("rst_busy",        64'(busy),        64'(0));
        chk("rst_ready",       64'(ready),       64'(1));
        chk("rst_overflow",    64'(overflow),    64'(0));
        reset = 1'b0;
        @(negedge sclk);
        chk_en = 1'b1;

        // Table of isolated single words
        for (int i = 0; i < 4; i++) run_word(tbl[i], $sformatf("word%0d", i));

        // Back-to-back: B 20 cycles after A
        rise_q.delete();
        pulse_load(40'hA5_A5A5_A5A5, 40'h0F_0F0F_0F0F);
        wait_cycles(19);
        pulse_load(40'h3C_3C3C_3C3C, 40'hC3_C3C3_C3C3);
        chk("b2b_ready_after_B", 64'(ready), 64'(0));
        wait_idle("b2b");
        chk("b2b_frames", 64'(rise_q.size()), 64'(2));
        if (rise_q.size() == 2) chk("b2b_period", 64'(rise_q[1] - rise_q[0]), 64'(FC));
        chk("b2b_overflow", 64'(overflow), 64'(0));

        // Load on the exact edge that moves buffered B into the shifter
        rise_q.delete();
        pulse_load(40'h11_1111_1111, 40'h22_2222_2222);   // returns at N1
        wait_cycles(10);                                   // N11
        pulse_load(40'h33_3333_3333, 40'h44_4444_4444);   // sampled P12, at N12
        wait_cycles(FC - 11);                              // N(FC+1)
        pulse_load(40'h55_5555_5555, 40'h66_6666_6666);   // sampled at transfer edge
        chk("simul_ready", 64'(ready), 64'(0));
        chk("simul_overflow", 64'(overflow), 64'(0));
        wait_idle("simul");
        chk("simul_frames", 64'(rise_q.size()), 64'(3));
        if (rise_q.size() == 3) begin
            chk("simul_period1", 64'(rise_q[1] - rise_q[0]), 64'(FC));
            chk("simul_period2", 64'(rise_q[2] - rise_q[1]), 64'(FC));
        end
        chk("simul_overflow_end", 64'(overflow), 64'(0));

        // Overflow: A, B, C within the first frame
        rise_q.delete();
        pulse_load(40'hAA_0000_0001, 40'hBB_0000_0002);
        wait_cycles(9);
        pulse_load(40'hAA_0000_0003, 40'hBB_0000_0004);
        wait_cycles(9);
        pulse_load(40'hAA_0000_0005, 40'hBB_0000_0006);
        chk("ovf_set", 64'(overflow), 64'(1));
        wait_idle("ovf");
        chk("ovf_frames", 64'(rise_q.size()), 64'(2));
        wait_cycles(10);
        chk("ovf_sticky", 64'(overflow), 64'(1));

        // Reset in the middle of a word (overflow still set from above)
        pulse_load(40'hF0_F0F0_F0F0, 40'h0F_0F0F_0F0F);
        wait_cycles(50);
        reset = 1'b1;
        #1;
        chk("mid_rst_serial_outL", 64'(serial_outL), 64'(0));
        chk("mid_rst_serial_outR", 64'(serial_outR), 64'(0));
        chk("mid_rst_frame_out",   64'(frame_out),   64'(0));
        chk("mid_rst_busy",        64'(busy),        64'(0));
        chk("mid_rst_ready",       64'(ready),       64'(1));
        chk("mid_rst_overflow",    64'(overflow),    64'(0));
        @(negedge sclk);
        reset = 1'b0;
        @(negedge sclk);
        run_word(tbl[1], "after_rst");

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rnd   = {$urandom(), $urandom()};
            dataL = rnd[WIDTH-1:0];
            rnd   = {$urandom(), $urandom()};
            dataR = rnd[WIDTH-1:0];
            load  = ($urandom_range(0, 99) < 2);
            @(negedge sclk);
        end
        load = 1'b0;
        wait_idle("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/msdap_out_serializer.md
Name: msdap_out_serializer

Overview:
Transmit side of the MSDAP serial protocol. Takes the 40-bit parallel left/right filter results and the outready strobe from the msdap core, and shifts them out MSB-first on one serial line per channel. A frame pulse marks the first bit of each word, mirroring the frame/serial format used on the input side. A one-deep holding buffer allows back-to-back results without gaps; an overflow flag reports lost words.

Parameters:
WIDTH, 40, bits per channel word (matches OUTPUT_WIDTH)
BIT_DIV, 4, sclk cycles each serial bit is held; legal range >= 1
CNT_BITS, 6, width of the bit counter; must satisfy 2^CNT_BITS > WIDTH+1

Ports:
sclk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
load  input  1  strobe, one sclk cycle; dataL/dataR valid when high (driven from outready)
dataL  input  WIDTH  left-channel parallel result
dataR  input  WIDTH  right-channel parallel result
serial_outL  output  1  left serial data, MSB first
serial_outR  output  1  right serial data, MSB first
frame_out  output  1  high for the full duration of bit 0 of each word
busy  output  1  high while a word is being shifted
ready  output  1  high when the holding buffer is empty
overflow  output  1  sticky; set when a word is dropped

Behaviour:
- Reset (async, immediate): state IDLE; holding buffer empty; shift registers and counters cleared. Outputs: serial_outL/R=0, frame_out=0, busy=0, ready=1, overflow=0. Any in-flight or held word is discarded.
- Holding buffer: load is sampled at a rising sclk edge.
  - Buffer empty, or being emptied by a transfer on the same edge: dataL/dataR are captured and the buffer becomes valid. No overflow.
  - Buffer full and not being emptied: the word is dropped, the buffer is unchanged, and overflow is set to 1.
- ready = ~holding_valid, registered.
- States: IDLE, SHIFT.
  - IDLE: if the holding buffer is valid, transfer it to the shift registers, clear the buffer, set bit_cnt=0 and div_cnt=0, and go to SHIFT. Otherwise remain in IDLE with serial outputs at 0.
  - SHIFT: serial_outX = shiftX[MSB]. div_cnt counts 0..BIT_DIV-1. When div_cnt reaches BIT_DIV-1, shift left by one and increment bit_cnt.
  - End of SHIFT: after the last bit's final cycle (bit_cnt = FRAME_LEN-1 and div_cnt = BIT_DIV-1):
    - Buffer valid: transfer directly with no idle gap and stay in SHIFT.
    - Buffer empty: go to IDLE.
  - FRAME_LEN = WIDTH, or WIDTH+1 when parity is enabled.
- Latency: load sampled at edge E0 produces holding valid after E0. At E1 the word is transferred, and serial_out=MSB, frame_out=1, busy=1 appear after E1.
- Bit timing: bit i occupies the cycles between edges E1+i*BIT_DIV and E1+(i+1)*BIT_DIV. frame_out is high only during bit 0 (BIT_DIV cycles).
- busy is 1 in SHIFT and 0 in IDLE. Outputs are registered, so there are no combinational paths from the inputs.
- Both channels always shift in lockstep and share frame_out.
- overflow is cleared only by reset.
- BIT_DIV=1 produces one bit per sclk cycle. Back-to-back words produce a continuous stream whose frame_out period is exactly FRAME_LEN*BIT_DIV cycles.

Optional Feature:
Macro SER_PARITY_EN.
- Defined: after the WIDTH data bits, one extra bit per channel carrying even parity, i.e. the XOR of all WIDTH bits of that channel's word. Parity is computed at transfer time. frame_out is 0 during the parity bit, FRAME_LEN = WIDTH+1, and busy covers the parity bit.
- Not defined: no parity logic and FRAME_LEN = WIDTH.

Test Plan:
- Single word (WIDTH=40, BIT_DIV=4, no parity): load dataL=40'h80_0000_0001, dataR=40'h00_0000_0000. Expect:
  - frame_out high for 4 cycles starting after the 2nd edge.
  - serial_outL = 1 for 4 cycles, 0 for 152 cycles, 1 for 4 cycles.
  - serial_outR = 0 throughout.
  - busy high for exactly 160 cycles, then IDLE with outputs 0.
- Back-to-back: load word A, then word B 20 cycles later. Expect ready=0 from B's capture until the transfer, the second frame_out rising exactly 160 cycles after the first, no gap, and overflow=0.
- Overflow: three loads (A, B, C) within the first 160 cycles. Expect A and B transmitted, C dropped, overflow=1 and held until reset.
- Simultaneous load and transfer: load asserted on the exact edge where buffered B moves to the shift register. Expect the new word captured, overflow stays 0, and three frames with no gaps.
- Reset mid-shift: assert reset at cycle 50 of a word. Expect serial_outL/R, frame_out and busy all 0 immediately, ready=1, and overflow=0. After release, a new load transmits correctly from bit 0.
- SER_PARITY_EN: dataL=40'h00_0000_0007, dataR=40'h00_0000_0003. Expect a 41-bit frame with parity bit L=1 and R=0, frame_out low during the parity bit, and busy=164 cycles.
